serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request pulse; sampled in IDLE and DONE only.
REQ-005 a  input  WIDTH  minuend; sampled on the edge that accepts start.
REQ-006 b  input  WIDTH  subtrahend; sampled on the edge that accepts start.
REQ-007 bin  input  1  borrow-in; sampled on the edge that accepts start.
REQ-008 busy  output  1  high while the subtraction is in progress.
REQ-009 done  output  1  one-cycle pulse; d, bout and err valid.
REQ-010 d  output  WIDTH  difference a - b - bin, modulo 2^WIDTH.
REQ-011 bout  output  1  borrow-out; 1 when a < b + bin (unsigned).
REQ-012 err  output  1  residue-check mismatch flag; qualified by done.

Function
REQ-013 FSM states IDLE, SHIFT, DONE; reset state IDLE.
REQ-014 IDLE: start=1 latches a, b, bin, clears bit counter, enters SHIFT; busy=1 from next cycle.
REQ-015 SHIFT: one bit per cycle, LSB first: d[i] = a[i]^b[i]^br; br_next = (~a[i]&b[i]) | (~(a[i]^b[i])&br); br initialised to bin.
REQ-016 SHIFT lasts exactly WIDTH cycles; after bit WIDTH-1, bout = final br and the FSM enters DONE.
REQ-017 DONE: done=1, busy=0 for exactly one cycle; then IDLE unless start=1, which is accepted as in IDLE.
REQ-018 Latency: start accepted on edge E0; done high in the cycle after edge E(WIDTH); 8 cycles of busy for WIDTH=8.
REQ-019 start during SHIFT is ignored; latched operands are unchanged.
REQ-020 d, bout and err hold their last values from DONE until the next accepted start; d is cleared when a new start is accepted.
REQ-021 Bit counter width is ceil(log2(WIDTH)); no wrap beyond WIDTH-1.

Reset
REQ-022 rst=1 forces IDLE immediately, regardless of clk, and aborts any operation in progress.
REQ-023 Reset values: busy=0, done=0, d=0, bout=0, err=0; internal borrow, counter and operand registers are 0.
REQ-024 The first start is accepted on the first rising edge after rst deasserts.

Configuration
REQ-025 Macro SERIAL_SUB_RESIDUE_CHECK_EN enables the mod-3 residue check.
REQ-026 When defined: on start, compute ra = (a mod 3 - b mod 3 - bin) mod 3; in DONE, err = 1 iff (d mod 3 - bout) mod 3 != ra (256 mod 3 = 1 for WIDTH=8).
REQ-027 When undefined: err port is present and tied to 0, and no residue logic is synthesised.

Structure
REQ-028 Shared package serial_sub_pkg holds WIDTH default, counter width constant, FSM state enum type and a mod-3 residue function.
REQ-029 One combinational sub-module full_subtractor_cell (a, b, bin -> d, bout) is instantiated once for the serial bit slice.

Verification
REQ-030 a=0x5A, b=0x23, bin=0, start pulse -> after 8 busy cycles done=1, d=0x37, bout=0, err=0.
REQ-031 a=0x10, b=0x20, bin=0 -> d=0xF0, bout=1; a=0x00, b=0x00, bin=1 -> d=0xFF, bout=1.
REQ-032 a=0xFF, b=0x00, bin=0, with start held high through SHIFT -> d=0xFF, bout=0; operands unchanged when a and b are altered mid-SHIFT; a new start is accepted in DONE.
REQ-033 Pulse rst during SHIFT cycle 4 -> busy, done, d, bout drop to 0 asynchronously; the next start (0x05-0x03) gives d=0x02.
REQ-034 With the macro defined, force one latched d bit to flip during SHIFT -> err=1 with done; without the macro, err=0 in every scenario.
REQ-035 Random-compare 1000 operand triples against a - b - bin; d and bout match every time, and done appears exactly 9 cycles after each start.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: default width, counter width,
// FSM state type and mod-3 residue helpers.
package serial_sub_pkg;

  localparam int unsigned SubWidthDef = 8;
  localparam int unsigned SubCntW     = $clog2(SubWidthDef);

  typedef enum logic [1:0] {StIdle, StShift, StDone} sub_state_e;

  // Bit i contributes 2^i mod 3, which alternates 1, 2, 1, 2, ...
  function automatic logic [1:0] mod3(input logic [31:0] v);
    logic [1:0] r;
    logic [2:0] t;
    r = 2'd0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) begin
        t = {1'b0, r} + (i[0] ? 3'd2 : 3'd1);
        if (t >= 3'd3) t = t - 3'd3;
        r = t[1:0];
      end
    end
    return r;
  endfunction

  function automatic logic [1:0] sub3(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] t;
    t = {1'b0, x} + 3'd3 - {1'b0, y};
    if (t >= 3'd3) t = t - 3'd3;
    return t[1:0];
  endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor slice: d = a - b - bin with borrow-out.
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one bit per cycle through a single full subtractor cell.
// Optional mod-3 residue check enabled by SERIAL_SUB_RESIDUE_CHECK_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = SubWidthDef
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             err
);

  localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  sub_state_e       r_state, w_state_next;
  logic [WIDTH-1:0] r_a, r_b, r_d;
  logic [CntW-1:0]  r_cnt;
  logic             r_br, r_bout;
  logic             w_accept, w_last, w_d_bit, w_br_next;
  logic [WIDTH-1:0] w_d_next;

  assign w_accept = start && ((r_state == StIdle) || (r_state == StDone));
  assign w_last   = (r_state == StShift) && (r_cnt == CntLast);
  // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at d[0].
  assign w_d_next = {w_d_bit, r_d[WIDTH-1:1]};

  full_subtractor_cell u_cell (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_br),
    .d    (w_d_bit),
    .bout (w_br_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = StShift;
      StShift: if (w_last) w_state_next = StDone;
      StDone:  w_state_next = w_accept ? StShift : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_d    <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_bout <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_br  <= bin;
      r_cnt <= '0;
      r_d   <= '0;
    end else if (r_state == StShift) begin
      r_a  <= r_a >> 1;
      r_b  <= r_b >> 1;
      r_br <= w_br_next;
      r_d  <= w_d_next;
      if (w_last) r_bout <= w_br_next;
      else        r_cnt  <= r_cnt + CntW'(1);
    end
  end

  assign busy = (r_state == StShift);
  assign done = (r_state == StDone);
  assign d    = r_d;
  assign bout = r_bout;

`ifdef SERIAL_SUB_RESIDUE_CHECK_EN
  // a - b - bin == d - bout * 2^WIDTH, and 2^WIDTH mod 3 is 1 for even WIDTH, 2 for odd.
  localparam logic [1:0] PowMod = (WIDTH % 2 == 0) ? 2'd1 : 2'd2;

  logic [1:0] r_ra, w_ra_in, w_rd;
  logic       r_err;

  assign w_ra_in = sub3(sub3(mod3(32'(a)), mod3(32'(b))), {1'b0, bin});
  assign w_rd    = sub3(mod3(32'(w_d_next)), w_br_next ? PowMod : 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ra  <= 2'd0;
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_ra <= w_ra_in;
    end else if (w_last) begin
      r_err <= (w_rd != r_ra);
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule
